// File: rtl/emulador_hcsr04_pkg.sv
// +--------------------------------------------------------------------------+
// | emulador_hcsr04_pkg                                                      |
// | State encoding and default timing constants for the HC-SR04 emulator.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package emulador_hcsr04_pkg;

   typedef enum logic [3:0] {
      inicial            = 4'd0,
      espera_trigger     = 4'd1,
      mede_trigger       = 4'd2,
      espera_fim_trigger = 4'd3,
      atraso             = 4'd4,
      eco                = 4'd5,
      fim_eco            = 4'd6,
      pausa              = 4'd7
   } estado_t;

   // Defaults assume a 50 MHz clock.
   localparam int c_clk_per_cm = 2941;
   localparam int c_trig_min   = 500;
   localparam int c_echo_delay = 25000;
   localparam int c_holdoff    = 50000;
   localparam int c_max_cm     = 400;
   localparam int c_timeout_cm = 660;
   localparam int c_dist_w     = 10;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/contador_m.sv
// +--------------------------------------------------------------------------+
// | contador_m                                                               |
// | Generic modulo-M up counter with async and sync clear.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module contador_m #(
   parameter int M = 100,
   parameter int N = $clog2(M)
) (
   input  logic         clock,
   input  logic         zera_as,
   input  logic         zera_s,
   input  logic         conta,
   output logic [N-1:0] q
);

   logic [N-1:0] r_q;

   always_ff @(posedge clock or posedge zera_as) begin
      if (zera_as) begin
         r_q <= '0;
      end else if (zera_s) begin
         r_q <= '0;
      end else if (conta) begin
         if (r_q == N'(M - 1)) begin
            r_q <= '0;
         end else begin
            r_q <= r_q + N'(1);
         end
      end
   end

   assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/emulador_hcsr04_fd.sv
// +--------------------------------------------------------------------------+
// | emulador_hcsr04_fd                                                       |
// | Datapath: cycle counter, cm counter, latched distance and target select. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module emulador_hcsr04_fd
   import emulador_hcsr04_pkg::*;
#(
   parameter int CLK_PER_CM = c_clk_per_cm,
   parameter int TRIG_MIN   = c_trig_min,
   parameter int ECHO_DELAY = c_echo_delay,
   parameter int HOLDOFF    = c_holdoff,
   parameter int MAX_CM     = c_max_cm,
   parameter int TIMEOUT_CM = c_timeout_cm,
   parameter int DIST_W     = c_dist_w
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DIST_W-1:0] distancia,
   input  logic              zera_ciclo,
   input  logic              conta_ciclo,
   input  logic              zera_cm,
   input  logic              conta_cm,
   input  logic              carrega_dist,
   output logic              trig_ok,
   output logic              atraso_fim,
   output logic              cm_wrap,
   output logic              eco_fim,
   output logic              pausa_fim
);

   localparam int c_ciclo_max = max2(max2(CLK_PER_CM, TRIG_MIN), max2(ECHO_DELAY, HOLDOFF));
   localparam int c_ciclo_w   = $clog2(c_ciclo_max);
   localparam int c_cm_max    = max2(MAX_CM, TIMEOUT_CM);
   localparam int c_cm_w      = $clog2(c_cm_max + 1);
   localparam logic [DIST_W-1:0] c_max_dist = DIST_W'(MAX_CM);

   logic [c_ciclo_w-1:0] w_ciclo;
   logic [c_cm_w-1:0]    w_cm;
   logic [c_cm_w-1:0]    w_alvo;
   logic [DIST_W-1:0]    r_dist;
   logic                 w_em_faixa;

   contador_m #(
      .M (c_ciclo_max),
      .N (c_ciclo_w)
   ) u_ciclo (
      .clock   (clock),
      .zera_as (reset),
      .zera_s  (zera_ciclo),
      .conta   (conta_ciclo),
      .q       (w_ciclo)
   );

   contador_m #(
      .M (c_cm_max + 1),
      .N (c_cm_w)
   ) u_cm (
      .clock   (clock),
      .zera_as (reset),
      .zera_s  (zera_cm),
      .conta   (conta_cm),
      .q       (w_cm)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_dist <= '0;
      end else if (carrega_dist) begin
         r_dist <= distancia;
      end
   end

   // Zero and anything above the range both report as no echo received.
   assign w_em_faixa = (r_dist != '0) && (r_dist <= c_max_dist);
   assign w_alvo     = w_em_faixa ? c_cm_w'(r_dist) : c_cm_w'(TIMEOUT_CM);

   // The validating edge is itself the TRIG_MIN-th high sample: the first
   // high sample is taken in espera_trigger, before this counter runs.
   assign trig_ok    = (w_ciclo == c_ciclo_w'(TRIG_MIN - 2));
   assign atraso_fim = (w_ciclo == c_ciclo_w'(ECHO_DELAY - 1));
   assign cm_wrap    = (w_ciclo == c_ciclo_w'(CLK_PER_CM - 1));
   assign pausa_fim  = (w_ciclo == c_ciclo_w'(HOLDOFF - 1));
   assign eco_fim    = cm_wrap && (w_cm == (w_alvo - c_cm_w'(1)));

endmodule

`default_nettype wire

// File: rtl/emulador_hcsr04_uc.sv
// +--------------------------------------------------------------------------+
// | emulador_hcsr04_uc                                                       |
// | Control FSM for the emulator, with registered Moore outputs.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module emulador_hcsr04_uc
   import emulador_hcsr04_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger,
   input  logic       trig_ok,
   input  logic       atraso_fim,
   input  logic       cm_wrap,
   input  logic       eco_fim,
   input  logic       pausa_fim,
   output logic       zera_ciclo,
   output logic       conta_ciclo,
   output logic       zera_cm,
   output logic       conta_cm,
   output logic       carrega_dist,
   output logic       echo,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   estado_t r_estado;
   estado_t w_prox;
   logic    r_echo;
   logic    r_ocupado;
   logic    r_pronto;

   always_comb begin
      w_prox       = r_estado;
      zera_ciclo   = 1'b0;
      conta_ciclo  = 1'b0;
      zera_cm      = 1'b0;
      conta_cm     = 1'b0;
      carrega_dist = 1'b0;
      case (r_estado)
         inicial: begin
            zera_ciclo = 1'b1;
            zera_cm    = 1'b1;
            w_prox     = espera_trigger;
         end
         espera_trigger: begin
            zera_ciclo = 1'b1;
            if (trigger) w_prox = mede_trigger;
         end
         mede_trigger: begin
            if (!trigger) begin
               w_prox = espera_trigger;
            end else if (trig_ok) begin
               carrega_dist = 1'b1;
               w_prox       = espera_fim_trigger;
            end else begin
               conta_ciclo = 1'b1;
            end
         end
         espera_fim_trigger: begin
            zera_ciclo = 1'b1;
            if (!trigger) w_prox = atraso;
         end
         atraso: begin
            if (atraso_fim) begin
               zera_ciclo = 1'b1;
               zera_cm    = 1'b1;
               w_prox     = eco;
            end else begin
               conta_ciclo = 1'b1;
            end
         end
         eco: begin
            // Cycle counter restarts every cm; the last wrap ends the echo.
            if (cm_wrap) begin
               zera_ciclo = 1'b1;
               conta_cm   = 1'b1;
               if (eco_fim) w_prox = fim_eco;
            end else begin
               conta_ciclo = 1'b1;
            end
         end
         fim_eco: begin
            zera_ciclo = 1'b1;
            w_prox     = pausa;
         end
         pausa: begin
            if (pausa_fim) begin
               zera_ciclo = 1'b1;
               w_prox     = espera_trigger;
            end else begin
               conta_ciclo = 1'b1;
            end
         end
         default: w_prox = inicial;
      endcase
   end

   // Outputs are decoded from the next state so they line up with r_estado.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado  <= inicial;
         r_echo    <= 1'b0;
         r_ocupado <= 1'b0;
         r_pronto  <= 1'b0;
      end else begin
         r_estado  <= w_prox;
         r_echo    <= (w_prox == eco);
         r_ocupado <= (w_prox inside {espera_fim_trigger, atraso, eco, fim_eco, pausa});
         r_pronto  <= (w_prox == fim_eco);
      end
   end

   assign echo      = r_echo;
   assign ocupado   = r_ocupado;
   assign pronto    = r_pronto;
   assign db_estado = r_estado;

endmodule

`default_nettype wire

// File: rtl/emulador_hcsr04.sv
// +--------------------------------------------------------------------------+
// | emulador_hcsr04                                                          |
// | HC-SR04 responder: trigger in, echo pulse proportional to distance out.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module emulador_hcsr04
   import emulador_hcsr04_pkg::*;
#(
   parameter int CLK_PER_CM = c_clk_per_cm,
   parameter int TRIG_MIN   = c_trig_min,
   parameter int ECHO_DELAY = c_echo_delay,
   parameter int HOLDOFF    = c_holdoff,
   parameter int MAX_CM     = c_max_cm,
   parameter int TIMEOUT_CM = c_timeout_cm,
   parameter int DIST_W     = c_dist_w
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              trigger,
   input  logic [DIST_W-1:0] distancia,
   output logic              echo,
   output logic              ocupado,
   output logic              pronto,
   output logic [3:0]        db_estado
);

   logic w_zera_ciclo;
   logic w_conta_ciclo;
   logic w_zera_cm;
   logic w_conta_cm;
   logic w_carrega_dist;
   logic w_trig_ok;
   logic w_atraso_fim;
   logic w_cm_wrap;
   logic w_eco_fim;
   logic w_pausa_fim;

   emulador_hcsr04_uc u_uc (
      .clock        (clock),
      .reset        (reset),
      .trigger      (trigger),
      .trig_ok      (w_trig_ok),
      .atraso_fim   (w_atraso_fim),
      .cm_wrap      (w_cm_wrap),
      .eco_fim      (w_eco_fim),
      .pausa_fim    (w_pausa_fim),
      .zera_ciclo   (w_zera_ciclo),
      .conta_ciclo  (w_conta_ciclo),
      .zera_cm      (w_zera_cm),
      .conta_cm     (w_conta_cm),
      .carrega_dist (w_carrega_dist),
      .echo         (echo),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .db_estado    (db_estado)
   );

   emulador_hcsr04_fd #(
      .CLK_PER_CM (CLK_PER_CM),
      .TRIG_MIN   (TRIG_MIN),
      .ECHO_DELAY (ECHO_DELAY),
      .HOLDOFF    (HOLDOFF),
      .MAX_CM     (MAX_CM),
      .TIMEOUT_CM (TIMEOUT_CM),
      .DIST_W     (DIST_W)
   ) u_fd (
      .clock        (clock),
      .reset        (reset),
      .distancia    (distancia),
      .zera_ciclo   (w_zera_ciclo),
      .conta_ciclo  (w_conta_ciclo),
      .zera_cm      (w_zera_cm),
      .conta_cm     (w_conta_cm),
      .carrega_dist (w_carrega_dist),
      .trig_ok      (w_trig_ok),
      .atraso_fim   (w_atraso_fim),
      .cm_wrap      (w_cm_wrap),
      .eco_fim      (w_eco_fim),
      .pausa_fim    (w_pausa_fim)
   );

endmodule

`default_nettype wire

// File: tb/tb_emulador_hcsr04.sv
// +--------------------------------------------------------------------------+
// | tb_emulador_hcsr04                                                       |
// | Self-checking bench for the HC-SR04 emulator with small timing values.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_emulador_hcsr04;
   import emulador_hcsr04_pkg::*;

   localparam int P_CLK   = 4;
   localparam int P_TRIG  = 3;
   localparam int P_DELAY = 5;
   localparam int P_HOLD  = 6;
   localparam int P_MAX   = 20;
   localparam int P_TO    = 25;
   localparam int P_DW    = 10;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            trigger = 1'b0;
   logic [P_DW-1:0] distancia = '0;
   logic            echo;
   logic            ocupado;
   logic            pronto;
   logic [3:0]      db_estado;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   emulador_hcsr04 #(
      .CLK_PER_CM (P_CLK),
      .TRIG_MIN   (P_TRIG),
      .ECHO_DELAY (P_DELAY),
      .HOLDOFF    (P_HOLD),
      .MAX_CM     (P_MAX),
      .TIMEOUT_CM (P_TO),
      .DIST_W     (P_DW)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .trigger   (trigger),
      .distancia (distancia),
      .echo      (echo),
      .ocupado   (ocupado),
      .pronto    (pronto),
      .db_estado (db_estado)
   );

   // Reference: echo width in cycles for a latched distance.
   function automatic int exp_width(input int d);
      if (d >= 1 && d <= P_MAX) return d * P_CLK;
      return P_TO * P_CLK;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Drives one trigger pulse and observes the full measurement cycle.
   task automatic measure(input int d, input int h, input bit pausa_pulse,
                          output bit ocup_ok, output int t_rise, output int width,
                          output bit pr_ok, output int t_hold, output bit echo_extra);
      distancia = P_DW'(d);
      trigger   = 1'b1;
      repeat (h) tick;
      trigger   = 1'b0;
      ocup_ok   = (ocupado === 1'b1);
      distancia = P_DW'($urandom_range(0, 1023));
      t_rise = 0;
      while (echo !== 1'b1 && t_rise < 200) begin
         tick;
         t_rise++;
      end
      width = 0;
      while (echo === 1'b1 && width < 2000) begin
         tick;
         width++;
      end
      pr_ok = (pronto === 1'b1) && (echo === 1'b0) && (ocupado === 1'b1);
      t_hold = 0;
      echo_extra = 1'b0;
      do begin
         tick;
         t_hold++;
         if (t_hold == 1) pr_ok = pr_ok && (pronto === 1'b0);
         if (pausa_pulse) begin
            if (t_hold == 1) trigger = 1'b1;
            if (t_hold == 4) trigger = 1'b0;
         end
         if (echo === 1'b1) echo_extra = 1'b1;
      end while (ocupado === 1'b1 && t_hold < 200);
      trigger = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) tick;
      checks++;
      if ({echo, ocupado, pronto} !== 3'b000) begin
         failures++;
         $display("FAIL reset_outputs: got echo/ocupado/pronto=%b required 000", {echo, ocupado, pronto});
      end
      checks++;
      if (db_estado !== 4'(inicial)) begin
         failures++;
         $display("FAIL reset_state: got %0d required %0d", db_estado, 4'(inicial));
      end
      reset = 1'b0;
      tick;
      checks++;
      if (db_estado !== 4'(espera_trigger)) begin
         failures++;
         $display("FAIL post_reset_state: got %0d required %0d", db_estado, 4'(espera_trigger));
      end
   endtask

   task automatic test_basic;
      bit ok, pr, ex;
      int tr, w, th;
      measure(7, P_TRIG, 1'b0, ok, tr, w, pr, th, ex);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_ocupado_on_valid: got 0 required 1"); end
      checks++;
      if (tr != P_DELAY + 1) begin failures++; $display("FAIL basic_rise: got %0d required %0d", tr, P_DELAY + 1); end
      checks++;
      if (w != exp_width(7)) begin failures++; $display("FAIL basic_width: got %0d required %0d", w, exp_width(7)); end
      checks++;
      if (!pr) begin failures++; $display("FAIL basic_pronto: got bad pulse required single cycle"); end
      checks++;
      if (th != P_HOLD + 1) begin failures++; $display("FAIL basic_holdoff: got %0d required %0d", th, P_HOLD + 1); end
   endtask

   task automatic test_runt;
      bit seen_echo, seen_ocup;
      seen_echo = 1'b0;
      seen_ocup = 1'b0;
      distancia = 10'd5;
      trigger   = 1'b1;
      repeat (P_TRIG - 1) tick;
      trigger   = 1'b0;
      repeat (40) begin
         tick;
         if (echo === 1'b1) seen_echo = 1'b1;
         if (ocupado === 1'b1) seen_ocup = 1'b1;
      end
      checks++;
      if (seen_echo) begin failures++; $display("FAIL runt_echo: got echo=1 required 0"); end
      checks++;
      if (seen_ocup) begin failures++; $display("FAIL runt_ocupado: got ocupado=1 required 0"); end
      checks++;
      if (db_estado !== 4'(espera_trigger)) begin
         failures++;
         $display("FAIL runt_state: got %0d required %0d", db_estado, 4'(espera_trigger));
      end
   endtask

   task automatic test_timeout;
      bit ok, pr, ex;
      int tr, w, th;
      int dists[2] = '{0, P_MAX + 1};
      foreach (dists[i]) begin
         measure(dists[i], P_TRIG, 1'b0, ok, tr, w, pr, th, ex);
         checks++;
         if (w != P_TO * P_CLK) begin
            failures++;
            $display("FAIL timeout_width d=%0d: got %0d required %0d", dists[i], w, P_TO * P_CLK);
         end
      end
   endtask

   task automatic test_random;
      bit ok, pr, ex;
      int tr, w, th, d, h;
      for (int i = 0; i < 8; i++) begin
         d = $urandom_range(0, P_TO + 5);
         if (i == 7) d = P_MAX;
         if (i == 6) d = 1;
         h = $urandom_range(P_TRIG, P_TRIG + 4);
         measure(d, h, 1'b0, ok, tr, w, pr, th, ex);
         checks++;
         if (tr != P_DELAY + 1) begin failures++; $display("FAIL rand_rise d=%0d: got %0d required %0d", d, tr, P_DELAY + 1); end
         checks++;
         if (w != exp_width(d)) begin failures++; $display("FAIL rand_width d=%0d: got %0d required %0d", d, w, exp_width(d)); end
         checks++;
         if (!pr || th != P_HOLD + 1) begin
            failures++;
            $display("FAIL rand_tail d=%0d: got pronto_ok=%0d hold=%0d required 1 %0d", d, pr, th, P_HOLD + 1);
         end
      end
   endtask

   task automatic test_latch_ignore;
      int  t, w;
      bit  extra;
      distancia = 10'd20;
      trigger   = 1'b1;
      repeat (P_TRIG) tick;
      trigger   = 1'b0;
      tick;
      tick;
      distancia = 10'd3;
      t = 0;
      while (echo !== 1'b1 && t < 100) begin
         tick;
         t++;
      end
      checks++;
      if (echo !== 1'b1) begin failures++; $display("FAIL latch_rise: got echo=%b required 1", echo); end
      w = 0;
      while (echo === 1'b1 && w < 500) begin
         tick;
         w++;
         if (w == 5) trigger = 1'b1;
         if (w == 10) trigger = 1'b0;
      end
      checks++;
      if (w != exp_width(20)) begin failures++; $display("FAIL latch_width: got %0d required %0d", w, exp_width(20)); end
      extra = 1'b0;
      repeat (60) begin
         tick;
         if (echo === 1'b1) extra = 1'b1;
      end
      checks++;
      if (extra) begin failures++; $display("FAIL ignored_trigger_echo: got second echo required none"); end
      checks++;
      if (ocupado !== 1'b0) begin failures++; $display("FAIL latch_idle: got ocupado=%b required 0", ocupado); end
   endtask

   task automatic test_async_reset;
      bit ok, pr, ex;
      int t, tr, w, th;
      distancia = 10'd9;
      trigger   = 1'b1;
      repeat (P_TRIG) tick;
      trigger   = 1'b0;
      t = 0;
      while (echo !== 1'b1 && t < 100) begin
         tick;
         t++;
      end
      repeat (10) tick;
      checks++;
      if (echo !== 1'b1) begin failures++; $display("FAIL areset_pre_echo: got %b required 1", echo); end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({echo, ocupado, pronto} !== 3'b000) begin
         failures++;
         $display("FAIL areset_outputs: got echo/ocupado/pronto=%b required 000", {echo, ocupado, pronto});
      end
      checks++;
      if (db_estado !== 4'(inicial)) begin failures++; $display("FAIL areset_state: got %0d required %0d", db_estado, 4'(inicial)); end
      @(posedge clock);
      @(posedge clock);
      #3;
      reset = 1'b0;
      tick;
      tick;
      measure(5, P_TRIG, 1'b0, ok, tr, w, pr, th, ex);
      checks++;
      if (tr != P_DELAY + 1 || w != exp_width(5)) begin
         failures++;
         $display("FAIL areset_recovery: got rise=%0d width=%0d required %0d %0d", tr, w, P_DELAY + 1, exp_width(5));
      end
   endtask

   task automatic test_back_to_back;
      bit ok, pr, ex;
      int tr, w, th;
      measure(11, P_TRIG + 1, 1'b1, ok, tr, w, pr, th, ex);
      checks++;
      if (w != exp_width(11)) begin failures++; $display("FAIL b2b_first_width: got %0d required %0d", w, exp_width(11)); end
      checks++;
      if (ex || th != P_HOLD + 1) begin
         failures++;
         $display("FAIL b2b_pausa_ignore: got extra_echo=%0d hold=%0d required 0 %0d", ex, th, P_HOLD + 1);
      end
      measure(6, P_TRIG, 1'b0, ok, tr, w, pr, th, ex);
      checks++;
      if (!ok || tr != P_DELAY + 1) begin
         failures++;
         $display("FAIL b2b_second_rise: got ocupado=%0d rise=%0d required 1 %0d", ok, tr, P_DELAY + 1);
      end
      checks++;
      if (w != exp_width(6)) begin failures++; $display("FAIL b2b_second_width: got %0d required %0d", w, exp_width(6)); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_runt;
      test_timeout;
      test_random;
      test_latch_ignore;
      test_async_reset;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
